// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver FSM state encoding.
package uart_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned BitIdxW   = $clog2(DataWidth);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_rd, do_wr;

    // Occupancy flags, accept decisions and next pointers; a pop frees a slot for a push.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // Storage is not reset, so mask the head while empty.
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a FWFT byte FIFO and sticky error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DataWidth-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_err
);

    localparam logic [15:0] HalfLoad = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullLoad = 16'(CLKS_PER_BIT - 1);

    logic [1:0]           sync_q;
    logic [1:0]           settle_q;
    logic                 rx_prev_q;
    logic                 rx_s;
    logic                 fall;

    rx_state_e            state_q;
    logic [15:0]          cnt_q;
    logic [BitIdxW-1:0]   bit_idx_q;
    logic [DataWidth-1:0] shift_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic                 cnt_zero;
    logic                 stop_sample;
    logic                 push;
    logic                 stop_bad;
    logic                 drop;

    // Two-flop synchronizer; rx_prev only tracks once the flops hold real line samples, so a
    // line held low across reset release is never mistaken for a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            settle_q  <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            settle_q  <= {settle_q[0], 1'b1};
            rx_prev_q <= settle_q[1] & sync_q[1];
        end
    end

    // Stop-bit decode and FIFO push/drop decisions, combinational so the byte lands next cycle.
    always_comb begin
        rx_s        = sync_q[1];
        fall        = rx_prev_q && !rx_s;
        cnt_zero    = (cnt_q == 16'd0);
        stop_sample = (state_q == StStop) && cnt_zero;
        push        = stop_sample && rx_s;
        stop_bad    = stop_sample && !rx_s;
        // While full the FIFO is non-empty, so rd_en always means a real pop.
        drop        = push && full && !rd_en;
        frame_err   = frame_err_q;
        overrun     = overrun_q;
    end

    // Receiver FSM with bit timing counter and sticky flags; a set event beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (stop_bad) begin
                frame_err_q <= 1'b1;
            end else if (clr_err) begin
                frame_err_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (fall) begin
                        cnt_q   <= HalfLoad;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (!rx_s) begin
                        cnt_q     <= FullLoad;
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end else begin
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_q <= StIdle;
                    end
                end
                StData: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        shift_q[bit_idx_q] <= rx_s;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        cnt_q              <= FullLoad;
                        if (bit_idx_q == BitIdxW'(DataWidth - 1)) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH(DataWidth),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_data(shift_q),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .empty  (empty),
        .full   (full)
    );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven bit-by-bit, a queue models the FIFO.
module tb_uart_rx_fifo;

    localparam int CLKS     = 16;
    localparam int DEPTH    = 8;
    localparam int FrameCyc = 10 * CLKS;
    // Iteration (cycles after the start-bit edge) whose cycle samples the stop bit:
    // 2 sync flops + edge cycle + half bit + 9 full bits.
    localparam int StopIter = 2 + CLKS / 2 + 9 * CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, frame_err, overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;
    logic       e_before, e_after;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CLKS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every real pop must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %02h required no data", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_data: got %02h required %02h", rd_data, mon_exp);
                end
            end
        end
    end

    // Drive one frame; optionally pulse rd_en / clr_err at a given iteration.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int pop_at,
                              input int clr_at);
        logic [9:0] bits;
        bits = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
        if (clr_at >= 0) begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end
        for (int c = 0; c < FrameCyc; c++) begin
            @(posedge clk);
            #1;
            rx = bits[c / CLKS];
            if (pop_at >= 0) rd_en = (c == pop_at);
            if (clr_at >= 0) clr_err = (c == clr_at);
            if (c == StopIter) e_before = empty;
            if (c == StopIter + 1) e_after = empty;
        end
        if (stop_ok) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
            @(posedge clk);
            #1 rx = 1'b1;
            repeat (CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    // Pop until the model is empty (bounded), then keep reading an empty FIFO.
    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1 rd_en = ($urandom_range(0, 2) != 0);
            n++;
        end
        @(posedge clk);
        #1 rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd_en = 1'b0;
        chk({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_drain_empty"}, 32'(empty), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rb;
        bit         ok;
        int         gap;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single byte and its landing cycle.
        send_frame(8'hA5, 1'b1, -1, -1);
        chk("a5_empty_at_stop", 32'(e_before), 32'd1);
        chk("a5_empty_after_stop", 32'(e_after), 32'd0);
        chk("a5_head", 32'(rd_data), 32'hA5);
        drain("a5");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        send_frame(8'h3C, 1'b1, -1, -1);
        check_state("b2b");
        drain("b2b");

        // Fill past capacity.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(8'h10 + i), 1'b1, -1, -1);
            if (i == 8) check_state("fill8");
        end
        chk("fill9_ovr", 32'(overrun), 32'd1);
        check_state("fill9");
        pulse_clr();
        chk("fill_clr_ovr", 32'(overrun), 32'd0);
        // Push while full, popping in the very same cycle.
        send_frame(8'hE7, 1'b1, StopIter, -1);
        chk("pushpop_full", 32'(full), 32'd1);
        chk("pushpop_ovr", 32'(overrun), 32'd0);
        drain("fill");

        // Framing error, clear, and a set that coincides with clr_err.
        send_frame(8'h55, 1'b0, -1, -1);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_empty", 32'(empty), 32'd1);
        pulse_clr();
        chk("ferr_clr", 32'(frame_err), 32'd0);
        send_frame(8'h55, 1'b0, -1, StopIter);
        chk("ferr_set_beats_clr", 32'(frame_err), 32'd1);
        pulse_clr();

        // Short low glitch: no byte, no flag, receiver still usable.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CLKS) @(posedge clk);
        #1;
        check_state("glitch");
        send_frame(8'h5A, 1'b1, -1, -1);
        drain("glitch");

        // Reset in the middle of data bit 3 of 0x81, line left low afterwards.
        v = 8'h81;
        @(posedge clk);
        #1 rx = 1'b0;
        for (int c = 1; c < 4 * CLKS + CLKS / 2; c++) begin
            @(posedge clk);
            #1 rx = (c < CLKS) ? 1'b0 : v[(c / CLKS) - 1];
        end
        rst = 1'b1;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        repeat (30) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CLKS) @(posedge clk);
        #1;
        check_state("midrst_idle");
        send_frame(8'h42, 1'b1, -1, -1);
        check_state("midrst_42");
        drain("midrst");

        // Randomized frames, gaps, errors, clears and drains.
        for (int i = 0; i < 36; i++) begin
            rb  = 8'($urandom);
            ok  = ($urandom_range(0, 7) != 0);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            send_frame(rb, ok, -1, -1);
            repeat (gap) @(posedge clk);
            #1;
            check_state("rnd");
            if ($urandom_range(0, 4) == 0) pulse_clr();
            if ($urandom_range(0, 5) == 0) drain("rnd");
        end
        drain("final");
        pulse_clr();
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: received-byte buffer depth; power of two, 2..256.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port rx, input, 1: asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 SHALL have port rd_en, input, 1: pop request for the head byte.
REQ-007 SHALL have port rd_data, output, 8: head-of-FIFO byte, valid whenever empty=0 (first-word-fall-through).
REQ-008 SHALL have port empty, output, 1: FIFO holds zero bytes.
REQ-009 SHALL have port full, output, 1: FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port frame_err, output, 1: sticky; a stop bit sampled low.
REQ-011 SHALL have port overrun, output, 1: sticky; a good byte was dropped because the FIFO was full.
REQ-012 SHALL have port clr_err, input, 1: synchronous clear of frame_err and overrun.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (2-cycle input latency).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: on synchronized rx falling edge (prev 1, now 0), load bit counter with CLKS_PER_BIT/2-1 and go to START.
REQ-016 START: at counter expiry (mid start bit), rx=0 -> reload CLKS_PER_BIT-1, bit index 0, go DATA; rx=1 -> glitch, return IDLE without error.
REQ-017 DATA: at each counter expiry, shift rx into bit[index], index+1, reload; after index 7, go STOP.
REQ-018 STOP: at counter expiry, rx=1 -> byte good, push if not full; rx=0 -> set frame_err, discard byte; both return IDLE.
REQ-019 A falling edge while in IDLE immediately after STOP SHALL be recognized in that same cycle (back-to-back frames, zero idle gap).
REQ-020 Push and pop in the same cycle SHALL both take effect; occupancy unchanged, including when full (pop frees slot first; push accepted, overrun not set).
REQ-021 Good byte while full with no pop SHALL be dropped, set overrun; FIFO contents unchanged.
REQ-022 rd_en while empty SHALL be ignored; pointers unchanged.
REQ-023 Pushed byte SHALL appear on rd_data with empty=0 one cycle after the STOP-sample cycle.
REQ-024 Pointers SHALL be log2(FIFO_DEPTH)+1 bits; full/empty from MSB-differing/equal compare; wrap-around transparent.
REQ-025 clr_err SHALL clear both sticky flags; a flag-set event in the same cycle wins (flag stays 1).

Reset
REQ-026 On rst: FSM=IDLE, counters 0, synchronizer=1, pointers 0, empty=1, full=0, frame_err=0, overrun=0, rd_data=0 (RAM contents not reset).
REQ-027 rst asserted mid-frame SHALL abort the frame; no partial byte pushed; after release, receiver waits for a fresh falling edge (line held low does not start a frame).

Structure
REQ-028 FSM state encoding and the 8-bit data-width constant SHALL live in shared package uart_pkg, also used by uart_tx.
REQ-029 Buffer SHALL be one sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full); receiver FSM stays in uart_rx_fifo.

Verification
REQ-030 Send 0xA5 at CLKS_PER_BIT=16 -> empty falls, rd_data=0xA5; rd_en one cycle -> empty=1.
REQ-031 Send 0x00,0xFF,0x3C back-to-back with zero idle -> popped in order 0x00,0xFF,0x3C; no flags.
REQ-032 Send 9 bytes, DEPTH=8, no reads -> full=1 after 8th, overrun=1 after 9th, pops yield bytes 1..8 only.
REQ-033 Frame 0x55 with stop bit low -> frame_err=1, FIFO stays empty; clr_err pulse -> frame_err=0.
REQ-034 rx low pulse of 4 cycles (< half bit) -> no byte, no flag, FSM back in IDLE.
REQ-035 rst asserted at data bit 3 of 0x81, then 0x42 sent -> only 0x42 received; full with simultaneous push+pop -> full stays 1, overrun 0.
